// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA timing recovery, active-video reconstruction and pixel probe
//
// Purpose: recovers line/frame timing from sampled HS/VS and reconstructs
// column/row/active-video. It locks after two consistent frames and
// captures the {R,G,B} value seen at a software-selected probe point.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   pix_en            pixel strobe; every input is sampled only when high
//   HS, VS            active-low horizontal / vertical sync
//   R, G, B           4-bit colour components
//   probe_x, probe_y  probe point, latched at each frame_start
//   col, row, de      reconstructed active position and active-video flag
//   locked            timing lock indicator
//   frame_start       one-clock pulse per locked frame
//   frame_count       count of locked frames (wraps)
//   probe_rgb         {R,G,B} captured at the probe point
//   probe_valid       one-clock pulse on capture
//   hs_err, vs_err    sticky timing error flags
module vga_sync_rx #(
   parameter int H_TOTAL  = 800,
   parameter int H_START  = 144,
   parameter int H_ACTIVE = 640,
   parameter int V_TOTAL  = 525,
   parameter int V_START  = 35,
   parameter int V_ACTIVE = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic        HS,
   input  logic        VS,
   input  logic [3:0]  R,
   input  logic [3:0]  G,
   input  logic [3:0]  B,
   input  logic [9:0]  probe_x,
   input  logic [8:0]  probe_y,
   output logic [9:0]  col,
   output logic [8:0]  row,
   output logic        de,
   output logic        locked,
   output logic        frame_start,
   output logic [15:0] frame_count,
   output logic [11:0] probe_rgb,
   output logic        probe_valid,
   output logic        hs_err,
   output logic        vs_err
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_FIRST = 10'(H_START);
   localparam logic [9:0] H_END   = 10'(H_START + H_ACTIVE);
   localparam logic [9:0] V_FIRST = 10'(V_START);
   localparam logic [9:0] V_END   = 10'(V_START + V_ACTIVE);

   state_t     state, state_n;
   logic [9:0] hcnt, hcnt_n;
   logic [9:0] vcnt, vcnt_n;
   logic       hs_prev, vs_prev;
   logic [9:0] probe_x_l;
   logic [8:0] probe_y_l;
   logic       hs_fall, vs_fall;
   logic       hs_bad, vs_bad, fs_n;
   logic       de_n, hit;
   logic [9:0] col_n;
   logic [8:0] row_n;

   assign hs_fall = hs_prev & ~HS;
   assign vs_fall = vs_prev & ~VS;

   // Next-state, counters and error detection. Error checks look at the
   // counter values before this sample's update: a well-formed line ends
   // with hcnt at H_TOTAL-1 exactly when the next HS fall arrives.
   always_comb begin
      state_n = state;
      hcnt_n  = hcnt;
      vcnt_n  = vcnt;
      hs_bad  = 1'b0;
      vs_bad  = 1'b0;
      fs_n    = 1'b0;
      if (pix_en) begin
         if (hs_fall)
            hcnt_n = '0;
         else if (hcnt != H_LAST)
            hcnt_n = hcnt + 10'd1;

         if (vs_fall)
            vcnt_n = '0;
         else if (hs_fall && (vcnt != V_LAST))
            vcnt_n = vcnt + 10'd1;

         if (state != SEARCH)
            hs_bad = hs_fall ? (hcnt != H_LAST) : (hcnt == H_LAST);
         if (state == LOCKED)
            vs_bad = vs_fall ? (vcnt != V_LAST) : (hs_fall && (vcnt == V_LAST));

         case (state)
            SEARCH: begin
               if (vs_fall)
                  state_n = ALIGN;
            end
            ALIGN: begin
               if (hs_bad)
                  state_n = SEARCH;
               else if (vs_fall && (vcnt == V_LAST)) begin
                  state_n = LOCKED;
                  fs_n    = 1'b1;
               end
            end
            LOCKED: begin
               if (hs_bad || vs_bad)
                  state_n = SEARCH;
               else if (vs_fall)
                  fs_n = 1'b1;
            end
            default: state_n = SEARCH;
         endcase
      end
   end

   // Position of the pixel sampled this cycle: the HS-fall sample is hcnt 0,
   // so the post-update counters name the pixel on the R/G/B inputs now.
   always_comb begin
      de_n  = (state_n == LOCKED) &&
              (hcnt_n >= H_FIRST) && (hcnt_n < H_END) &&
              (vcnt_n >= V_FIRST) && (vcnt_n < V_END);
      col_n = '0;
      row_n = '0;
      if (de_n) begin
         col_n = hcnt_n - H_FIRST;
         row_n = 9'(vcnt_n - V_FIRST);
      end
      // col/row never leave the active window, so an out-of-window probe
      // point can never match.
      hit = de_n && (col_n == probe_x_l) && (row_n == probe_y_l);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= SEARCH;
      else
         state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt        <= '0;
         vcnt        <= '0;
         hs_prev     <= 1'b1;
         vs_prev     <= 1'b1;
         probe_x_l   <= '0;
         probe_y_l   <= '0;
         col         <= '0;
         row         <= '0;
         de          <= 1'b0;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
         probe_rgb   <= '0;
         probe_valid <= 1'b0;
         hs_err      <= 1'b0;
         vs_err      <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         probe_valid <= 1'b0;
         if (pix_en) begin
            hs_prev     <= HS;
            vs_prev     <= VS;
            hcnt        <= hcnt_n;
            vcnt        <= vcnt_n;
            locked      <= (state_n == LOCKED);
            de          <= de_n;
            col         <= col_n;
            row         <= row_n;
            frame_start <= fs_n;
            if (fs_n) begin
               frame_count <= frame_count + 16'd1;
               probe_x_l   <= probe_x;
               probe_y_l   <= probe_y;
            end
            if (hs_bad)
               hs_err <= 1'b1;
            if (vs_bad)
               vs_err <= 1'b1;
            if (hit) begin
               probe_rgb   <= {R, G, B};
               probe_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - scoreboard testbench for vga_sync_rx with a reduced timing geometry
module tb_vga_sync_rx;

   localparam int HT = 20, HST = 5, HA = 10;
   localparam int VT = 12, VST = 3, VA = 6;
   localparam int HSW = 2, VSW = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_en = 1'b0;
   logic        HS = 1'b1, VS = 1'b1;
   logic [3:0]  R = '0, G = '0, B = '0;
   logic [9:0]  probe_x = '0;
   logic [8:0]  probe_y = '0;
   logic [9:0]  col;
   logic [8:0]  row;
   logic        de, locked, frame_start, probe_valid, hs_err, vs_err;
   logic [15:0] frame_count;
   logic [11:0] probe_rgb;

   always #5 clk = ~clk;

   vga_sync_rx #(
      .H_TOTAL(HT), .H_START(HST), .H_ACTIVE(HA),
      .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VA)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .HS(HS), .VS(VS),
      .R(R), .G(G), .B(B), .probe_x(probe_x), .probe_y(probe_y),
      .col(col), .row(row), .de(de), .locked(locked),
      .frame_start(frame_start), .frame_count(frame_count),
      .probe_rgb(probe_rgb), .probe_valid(probe_valid),
      .hs_err(hs_err), .vs_err(vs_err)
   );

   typedef struct {
      logic [9:0]  col;
      logic [8:0]  row;
      logic        de, locked, fs, pv, herr, verr;
      logic [15:0] fc;
      logic [11:0] prgb;
   } exp_t;

   exp_t q[$];
   exp_t m_last;
   int   n_vec = 0, n_bad = 0;
   int   de_cnt = 0, pv_cnt = 0;
   bit   gap_rand = 0, abc_mode = 0;

   // Reference model: distance from last HS fall, lines since last VS fall,
   // acquisition stage 0=searching, 1=one frame seen, 2=locked.
   int          m_h, m_v, m_stage;
   bit          m_hsp, m_vsp, m_herr, m_verr;
   logic [15:0] m_fc;
   logic [9:0]  m_px;
   logic [8:0]  m_py;
   logic [11:0] m_rgb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   function automatic exp_t reset_exp();
      exp_t e;
      e.col = '0; e.row = '0; e.de = 0; e.locked = 0; e.fs = 0; e.pv = 0;
      e.herr = 0; e.verr = 0; e.fc = '0; e.prgb = '0;
      return e;
   endfunction

   task automatic model_reset();
      m_h = 0; m_v = 0; m_stage = 0;
      m_hsp = 1; m_vsp = 1; m_herr = 0; m_verr = 0;
      m_fc = '0; m_px = '0; m_py = '0; m_rgb = '0;
      m_last = reset_exp();
   endtask

   task automatic model_step(input logic hs, input logic vs, input logic [11:0] rgb,
                             input logic [9:0] px, input logic [8:0] py, output exp_t e);
      bit hf, vf, he, ve;
      hf = m_hsp && !hs;
      vf = m_vsp && !vs;
      he = (m_stage != 0) && (hf ? (m_h != HT - 1) : (m_h == HT - 1));
      ve = (m_stage == 2) && (vf ? (m_v != VT - 1) : (hf && m_v == VT - 1));
      e.fs = 0;
      if (he || ve)
         m_stage = 0;
      else if (vf) begin
         if (m_stage == 0)
            m_stage = 1;
         else if (m_v == VT - 1) begin
            m_stage = 2;
            e.fs = 1;
         end
      end
      m_herr = m_herr | he;
      m_verr = m_verr | ve;
      m_h = hf ? 0 : ((m_h + 1 > HT - 1) ? HT - 1 : m_h + 1);
      if (vf)
         m_v = 0;
      else if (hf)
         m_v = (m_v + 1 > VT - 1) ? VT - 1 : m_v + 1;
      e.locked = (m_stage == 2);
      e.de  = e.locked && m_h >= HST && m_h < HST + HA && m_v >= VST && m_v < VST + VA;
      e.col = e.de ? 10'(m_h - HST) : 10'd0;
      e.row = e.de ? 9'(m_v - VST) : 9'd0;
      e.pv  = e.de && (e.col == m_px) && (e.row == m_py);
      if (e.pv)
         m_rgb = rgb;
      if (e.fs) begin
         m_fc = m_fc + 16'd1;
         m_px = px;
         m_py = py;
      end
      e.fc = m_fc; e.prgb = m_rgb; e.herr = m_herr; e.verr = m_verr;
      m_hsp = hs;
      m_vsp = vs;
      m_last = e;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pix_en = 0;
      end
   endtask

   task automatic sample(input logic hs, input logic vs, input logic [11:0] rgb);
      exp_t e;
      int   g;
      @(negedge clk);
      pix_en = 1; HS = hs; VS = vs; {R, G, B} = rgb;
      model_step(hs, vs, rgb, probe_x, probe_y, e);
      q.push_back(e);
      g = gap_rand ? int'($urandom_range(0, 5)) : 3;
      if (g > 0) begin
         @(negedge clk);
         pix_en = 0;
         repeat (g - 1) @(negedge clk);
      end
   endtask

   task automatic rand_probe();
      case ($urandom_range(0, 2))
         0: begin probe_x = 10'($urandom_range(0, HA - 1)); probe_y = 9'($urandom_range(0, VA - 1)); end
         1: begin probe_x = 10'($urandom_range(HA, 1023)); probe_y = 9'($urandom_range(0, VA - 1)); end
         default: begin probe_x = 10'($urandom_range(0, 1023)); probe_y = 9'($urandom_range(VA, 511)); end
      endcase
   endtask

   task automatic do_reset();
      idle(3);
      #2 rst = 1;
      #1;
      chk("rst_locked", locked, 0);
      chk("rst_col", col, 0);
      chk("rst_row", row, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_hs_err", hs_err, 0);
      chk("rst_vs_err", vs_err, 0);
      chk("rst_de", de, 0);
      model_reset();
      idle(2);
      rst = 0;
   endtask

   task automatic pause();
      idle(2);
      repeat (100) begin
         @(negedge clk);
         pix_en = 0;
         chk("pause_frame_start", frame_start, 0);
         chk("pause_probe_valid", probe_valid, 0);
      end
      chk("pause_col", col, m_last.col);
      chk("pause_row", row, m_last.row);
      chk("pause_hs_err", hs_err, m_last.herr);
      chk("pause_vs_err", vs_err, m_last.verr);
   endtask

   task automatic send_frame(input int hf_ln, input int vf_ln, input int pause_ln, input int rst_ln);
      logic        hs, vs;
      logic [11:0] rgb;
      for (int y = 0; y < VT; y++) begin
         for (int x = 0; x < HT; x++) begin
            if (y == rst_ln && x == 8) begin
               do_reset();
               return;
            end
            hs = (x >= HSW);
            vs = (y >= VSW);
            if (y == hf_ln && x == 10) hs = 0;
            if (y == vf_ln) vs = 0;
            rgb = 12'($urandom_range(0, 4095));
            if (abc_mode && x == HST && y == VST) rgb = 12'hABC;
            if (gap_rand && x == 0 && y == VT / 2) rand_probe();
            sample(hs, vs, rgb);
            if (y == pause_ln && x == 8) pause();
         end
      end
   endtask

   // exp_de / exp_pv < 0 leave the per-frame totals to the per-cycle monitor.
   task automatic run_frame(input string tag, input int hf_ln, input int vf_ln, input int pause_ln,
                            input int exp_de, input int exp_pv);
      int d0, p0;
      d0 = de_cnt;
      p0 = pv_cnt;
      send_frame(hf_ln, vf_ln, pause_ln, -1);
      idle(2);
      if (exp_de >= 0) chk({tag, "_de_count"}, de_cnt - d0, exp_de);
      if (exp_pv >= 0) chk({tag, "_pv_count"}, pv_cnt - p0, exp_pv);
   endtask

   // Monitor: after every clock, pop the expectation for a sampled cycle or
   // expect held values with pulses cleared for an idle one.
   initial begin
      exp_t last;
      bit   took;
      last = reset_exp();
      forever begin
         @(posedge clk);
         took = pix_en && !rst;
         @(negedge clk);
         if (rst)
            last = reset_exp();
         else begin
            if (took) begin
               if (q.size() == 0) begin
                  n_vec++; n_bad++;
                  $display("FAIL scoreboard_empty t=%0t got=0 expected=1", $time);
               end else
                  last = q.pop_front();
            end else begin
               last.fs = 0;
               last.pv = 0;
            end
            chk("col", col, last.col);
            chk("row", row, last.row);
            chk("de", de, last.de);
            chk("locked", locked, last.locked);
            chk("frame_start", frame_start, last.fs);
            chk("frame_count", frame_count, last.fc);
            chk("probe_rgb", probe_rgb, last.prgb);
            chk("probe_valid", probe_valid, last.pv);
            chk("hs_err", hs_err, last.herr);
            chk("vs_err", vs_err, last.verr);
            if (took) begin
               de_cnt += int'(de);
               pv_cnt += int'(probe_valid);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t got=running expected=finished", $time);
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      chk("init_locked", locked, 0);
      chk("init_frame_count", frame_count, 0);
      chk("init_hs_err", hs_err, 0);
      chk("init_vs_err", vs_err, 0);
      rst = 0;

      // Ideal timing, probe at (0,0) with a marked pixel.
      abc_mode = 1;
      probe_x = 0;
      probe_y = 0;
      run_frame("ideal1", -1, -1, -1, 0, 0);
      chk("ideal1_locked", locked, 0);
      run_frame("ideal2", -1, -1, -1, HA * VA, 1);
      chk("ideal2_locked", locked, 1);
      run_frame("ideal3", -1, -1, -1, HA * VA, 1);
      chk("ideal3_frame_count", frame_count, 2);
      chk("ideal3_probe_rgb", probe_rgb, 12'hABC);
      abc_mode = 0;

      // Random strobe spacing, colours and probe points (in and out of window).
      gap_rand = 1;
      repeat (3) begin
         rand_probe();
         run_frame("random", -1, -1, -1, HA * VA, -1);
      end
      gap_rand = 0;
      chk("random_frame_count", frame_count, 5);

      // Long strobe gap mid-line.
      probe_x = 2;
      probe_y = 1;
      run_frame("pause", -1, -1, 5, HA * VA, 1);
      chk("pause_frame_count", frame_count, 6);

      // Premature VS fall.
      run_frame("vsfault", -1, 7, -1, -1, -1);
      chk("vsfault_vs_err", vs_err, 1);
      chk("vsfault_hs_err", hs_err, 0);
      chk("vsfault_locked", locked, 0);
      chk("vsfault_frame_count", frame_count, 7);
      run_frame("vsrelock1", -1, -1, -1, 0, 0);
      chk("vsrelock1_locked", locked, 0);
      run_frame("vsrelock2", -1, -1, -1, HA * VA, 1);
      chk("vsrelock2_locked", locked, 1);
      chk("vsrelock2_vs_err", vs_err, 1);

      // Extra HS fall mid-line.
      run_frame("hsfault", 6, -1, -1, -1, -1);
      chk("hsfault_hs_err", hs_err, 1);
      chk("hsfault_locked", locked, 0);
      run_frame("hsrelock1", -1, -1, -1, 0, 0);
      run_frame("hsrelock2", -1, -1, -1, HA * VA, 1);
      chk("hsrelock2_locked", locked, 1);
      chk("hsrelock2_hs_err", hs_err, 1);
      chk("hsrelock2_frame_count", frame_count, 10);

      // Reset in the middle of a locked frame, then reacquire.
      send_frame(-1, -1, -1, 5);
      run_frame("rrelock1", -1, -1, -1, 0, 0);
      chk("rrelock1_locked", locked, 0);
      run_frame("rrelock2", -1, -1, -1, HA * VA, 1);
      chk("rrelock2_locked", locked, 1);
      chk("rrelock2_frame_count", frame_count, 1);

      idle(4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
